// File: rtl/fp_square.sv
// Iterative unsigned fixed-point squarer: out = floor(in*in / 2^FRAC_WIDTH), saturated.
// One shift-add step per clock, WIDTH cycles of latency, go/done handshake.
module fp_square #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 32,
    parameter int FRAC_WIDTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
        $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [IDX_W-1:0]     idx_r;
    logic [WIDTH-1:0]     out_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 overflow_r;

    logic [WIDTH:0]       addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     wide_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   scaled_s;
    logic                 sat_s;
    logic                 last_s;

    // Shift-add datapath; on the last iteration acc_next_s is the full exact product.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
        wide_s     = {sum_s, acc_r[WIDTH-1:0]};
        acc_next_s = (2*WIDTH)'(wide_s >> 1);
        scaled_s   = acc_next_s >> FRAC_WIDTH;
        sat_s      = |scaled_s[2*WIDTH-1:WIDTH];
        last_s     = (state_r == RUN) && (idx_r == IDX_W'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (go) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture and iteration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            idx_r    <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (go) begin
                        mcand_r  <= in;
                        mplier_r <= in;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        idx_r    <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_r >> 1;
                    if (last_s) begin
                        idx_r <= {IDX_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake and result; result loads on the completion edge itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r      <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= last_s;
            busy_r <= (next_state_s == RUN);
            if (last_s) begin
                overflow_r <= sat_s;
                if (sat_s) begin
                    out_r <= {WIDTH{1'b1}};
                end else begin
                    out_r <= scaled_s[WIDTH-1:0];
                end
            end
        end
    end

    assign out      = out_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_fp_square.sv
// Directed bench for fp_square: 32-bit integer instance and a 16-bit Q8.8 instance.
module tb_fp_square;

    logic        clk = 1'b0;
    logic        reset;
    logic        go32, go16;
    logic [31:0] in32, out32;
    logic [15:0] in16, out16;
    logic        done32, busy32, ovf32;
    logic        done16, busy16, ovf16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_square #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0)) dut32 (
        .clk(clk), .reset(reset), .go(go32), .in(in32),
        .out(out32), .done(done32), .busy(busy32), .overflow(ovf32)
    );

    fp_square #(.WIDTH(16), .INT_WIDTH(8), .FRAC_WIDTH(8)) dut16 (
        .clk(clk), .reset(reset), .go(go16), .in(in16),
        .out(out16), .done(done16), .busy(busy16), .overflow(ovf16)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_out, input logic exp_ovf);
        int cyc;
        go32 = 1'b1;
        in32 = a;
        step();
        go32 = 1'b0;
        in32 = 32'h0;
        cyc  = 0;
        while (!done32 && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd32);
        chk({tag, "_out"}, 64'(out32), 64'(exp_out));
        chk({tag, "_ovf"}, 64'(ovf32), 64'(exp_ovf));
    endtask

    task automatic op16(input string tag, input logic [15:0] a,
                        input logic [15:0] exp_out, input logic exp_ovf);
        int cyc;
        go16 = 1'b1;
        in16 = a;
        step();
        go16 = 1'b0;
        in16 = 16'h0;
        cyc  = 0;
        while (!done16 && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd16);
        chk({tag, "_out"}, 64'(out16), 64'(exp_out));
        chk({tag, "_ovf"}, 64'(ovf16), 64'(exp_ovf));
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at, cyc;
        logic [31:0] out_at_done;
        logic        ovf_at_done;

        reset = 1'b0;
        go32  = 1'b0;
        go16  = 1'b0;
        in32  = 32'h0;
        in16  = 16'h0;
        #1;
        chk("rst_out", 64'(out32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_ovf", 64'(ovf32), 64'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // in = 3: exact latency, busy width, single done, held result
        go32 = 1'b1;
        in32 = 32'd3;
        step();
        go32 = 1'b0;
        in32 = 32'h0;
        busy_cnt    = busy32 ? 1 : 0;
        done_cnt    = 0;
        done_at     = 0;
        out_at_done = 32'h0;
        ovf_at_done = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (busy32) busy_cnt++;
            if (done32) begin
                done_cnt++;
                done_at     = i;
                out_at_done = out32;
                ovf_at_done = ovf32;
            end
        end
        chk("sq3_done_at", 64'(done_at), 64'd32);
        chk("sq3_done_cnt", 64'(done_cnt), 64'd1);
        chk("sq3_busy_cnt", 64'(busy_cnt), 64'd32);
        chk("sq3_out", 64'(out_at_done), 64'd9);
        chk("sq3_ovf", 64'(ovf_at_done), 64'd0);
        chk("sq3_hold", 64'(out32), 64'd9);

        op32("sq0", 32'd0, 32'd0, 1'b0);
        op32("sq65535", 32'd65535, 32'hFFFE0001, 1'b0);
        op32("sq65536", 32'd65536, 32'hFFFFFFFF, 1'b1);
        op32("sqmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

        op16("q_1p5", 16'h0180, 16'h0240, 1'b0);
        op16("q_lsb", 16'h0001, 16'h0000, 1'b0);
        op16("q_16", 16'h1000, 16'hFFFF, 1'b1);

        // go re-pulsed at cycle 10 of an in-flight op is ignored
        go32 = 1'b1;
        in32 = 32'd5;
        step();
        go32 = 1'b0;
        repeat (9) step();
        go32 = 1'b1;
        in32 = 32'd7;
        step();
        go32 = 1'b0;
        in32 = 32'h0;
        cyc  = 10;
        while (!done32 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("repulse_lat", 64'(cyc), 64'd32);
        chk("repulse_out", 64'(out32), 64'd25);
        chk("repulse_ovf", 64'(ovf32), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done32) done_cnt++;
        end
        chk("repulse_no_2nd_done", 64'(done_cnt), 64'd0);

        // go held high: back-to-back results WIDTH+1 cycles apart
        go32 = 1'b1;
        in32 = 32'd2;
        step();
        in32 = 32'd4;
        cyc  = 0;
        while (!done32 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("b2b_first_lat", 64'(cyc), 64'd32);
        chk("b2b_first_out", 64'(out32), 64'd4);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done32 && cyc < 100);
        go32 = 1'b0;
        chk("b2b_spacing", 64'(cyc), 64'd33);
        chk("b2b_second_out", 64'(out32), 64'd16);
        step();
        step();
        chk("b2b_idle", 64'(busy32), 64'd0);

        // asynchronous reset mid-operation, between clock edges
        go32 = 1'b1;
        in32 = 32'd100;
        step();
        go32 = 1'b0;
        repeat (14) step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_done", 64'(done32), 64'd0);
        chk("arst_out", 64'(out32), 64'd0);
        chk("arst_ovf", 64'(ovf32), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done32) done_cnt++;
        end
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done32 || busy32) done_cnt++;
        end
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        op32("arst_sq12", 32'd12, 32'd144, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
